// File: rtl/int_controller.sv
// int_controller: prioritized, vectored interrupt controller with per-source
// edge/level sensing, maskable pending bits and sticky overflow flags.
module int_controller #(
  parameter int N_SRC = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100,
  parameter int VEC_STRIDE = 16,
  parameter logic [N_SRC-1:0] LEVEL_MASK = '0,
  localparam int IW = N_SRC > 1 ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             ovf_clr,
  input  logic             int_ack,
  input  logic             rfe,
  output logic             int_req,
  output logic [IW-1:0]    int_id,
  output logic [31:0]      vec_addr,
  output logic             in_service,
  output logic [N_SRC-1:0] mask_q,
  output logic [N_SRC-1:0] pend_q,
  output logic [N_SRC-1:0] ovf_q
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state;
  logic [N_SRC-1:0] sync1, sync2, prev, elig, edges, clr;
  logic [2:0] armed;
  logic [IW-1:0] win;
  logic take;
  function automatic logic [31:0] vec(input logic [IW-1:0] id);
    return VEC_BASE + 32'(id) * 32'(VEC_STRIDE);
  endfunction
  // Edges stay suppressed until prev holds a real post-reset sample, so a
  // line held high through reset never looks like a fresh rising edge.
  assign edges = sync2 & ~prev & ~LEVEL_MASK & {N_SRC{armed[2]}};
  assign elig = pend_q & mask_q;
  assign take = state == REQ && int_ack && |elig;
  assign clr = take ? N_SRC'(1) << win : '0;
  always_comb begin
    win = '0;
    for (int i = N_SRC - 1; i >= 0; i--) if (elig[i]) win = IW'(i);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      armed <= '0;
      mask_q <= '1;
      pend_q <= '0;
      ovf_q <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      prev <= sync2;
      armed <= {armed[1:0], 1'b1};
      if (mask_wr) mask_q <= mask_wdata;
      pend_q <= (LEVEL_MASK & sync2) | (~LEVEL_MASK & ((pend_q & ~clr) | edges));
      ovf_q <= (ovf_clr ? '0 : ovf_q) | (edges & pend_q & ~clr);
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      int_req <= 1'b0;
      in_service <= 1'b0;
      int_id <= '0;
      vec_addr <= VEC_BASE;
    end else
      case (state)
        IDLE:
          if (|elig) begin
            state <= REQ;
            int_req <= 1'b1;
            int_id <= win;
            vec_addr <= vec(win);
          end
        REQ:
          if (!(|elig)) begin
            state <= IDLE;
            int_req <= 1'b0;
          end else begin
            int_id <= win;
            vec_addr <= vec(win);
            if (int_ack) begin
              state <= SERVICE;
              int_req <= 1'b0;
              in_service <= 1'b1;
            end
          end
        SERVICE:
          if (rfe) begin
            state <= IDLE;
            in_service <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed scenarios plus random traffic on an all-edge
// instance and an instance with source 0 level-sensitive, against a reference model.
module tb_int_controller;
  logic clk = 0, rst = 1;
  logic [3:0] irq_src = 0, mask_wdata = 0;
  logic mask_wr = 0, ovf_clr = 0, int_ack = 0, rfe = 0;
  logic d_req [2], d_svc [2];
  logic [1:0] d_id [2];
  logic [31:0] d_vec [2];
  logic [3:0] d_mask [2], d_pend [2], d_ovf [2];
  int n_tests = 0, n_fail = 0;
  // reference model: sampled irq history, pending/overflow/mask sets, request state
  logic [3:0] m_pend [2], m_ovf [2], m_mask [2], h0 [2], h1 [2], h2 [2];
  int m_n [2], m_st [2];
  logic m_req [2], m_svc [2];
  logic [1:0] m_id [2];
  always #5 clk = ~clk;
  int_controller dut_e (
    .clk(clk), .rst(rst), .irq_src(irq_src), .mask_wr(mask_wr), .mask_wdata(mask_wdata),
    .ovf_clr(ovf_clr), .int_ack(int_ack), .rfe(rfe), .int_req(d_req[0]), .int_id(d_id[0]),
    .vec_addr(d_vec[0]), .in_service(d_svc[0]), .mask_q(d_mask[0]), .pend_q(d_pend[0]),
    .ovf_q(d_ovf[0]));
  int_controller #(.LEVEL_MASK(4'b0001)) dut_l (
    .clk(clk), .rst(rst), .irq_src(irq_src), .mask_wr(mask_wr), .mask_wdata(mask_wdata),
    .ovf_clr(ovf_clr), .int_ack(int_ack), .rfe(rfe), .int_req(d_req[1]), .int_id(d_id[1]),
    .vec_addr(d_vec[1]), .in_service(d_svc[1]), .mask_q(d_mask[1]), .pend_q(d_pend[1]),
    .ovf_q(d_ovf[1]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_ovf[k] = 0; m_mask[k] = 4'hF;
      h0[k] = 0; h1[k] = 0; h2[k] = 0; m_n[k] = 0;
      m_st[k] = 0; m_req[k] = 0; m_svc[k] = 0; m_id[k] = 0;
    end
  endtask
  // one rising clock edge of the model; h1 is the synchronized level, h2 the one before it
  task automatic step(input int k);
    logic [3:0] lm, np, no;
    int w;
    logic take, ed, cl;
    lm = k ? 4'b0001 : 4'b0000;
    w = lowest(m_pend[k] & m_mask[k]);
    take = m_st[k] == 1 && w >= 0 && int_ack;
    np = m_pend[k];
    no = ovf_clr ? 4'h0 : m_ovf[k];
    for (int i = 0; i < 4; i++) begin
      ed = h1[k][i] && !h2[k][i] && m_n[k] >= 3;
      cl = take && w == i;
      if (lm[i]) np[i] = h1[k][i];
      else begin
        if (ed && m_pend[k][i] && !cl) no[i] = 1;
        np[i] = (m_pend[k][i] && !cl) || ed;
      end
    end
    if (m_st[k] == 0) begin
      if (w >= 0) begin m_st[k] = 1; m_req[k] = 1; m_id[k] = 2'(w); end
    end else if (m_st[k] == 1) begin
      if (w < 0) begin m_st[k] = 0; m_req[k] = 0; end
      else begin
        m_id[k] = 2'(w);
        if (int_ack) begin m_st[k] = 2; m_req[k] = 0; m_svc[k] = 1; end
      end
    end else if (rfe) begin m_st[k] = 0; m_svc[k] = 0; end
    if (mask_wr) m_mask[k] = mask_wdata;
    m_pend[k] = np; m_ovf[k] = no;
    h2[k] = h1[k]; h1[k] = h0[k]; h0[k] = irq_src;
    m_n[k]++;
  endtask
  task automatic compare_all(input int k);
    string p;
    p = k ? "lvl" : "edg";
    check({p, ".int_req"}, 32'(d_req[k]), 32'(m_req[k]));
    check({p, ".in_service"}, 32'(d_svc[k]), 32'(m_svc[k]));
    check({p, ".int_id"}, 32'(d_id[k]), 32'(m_id[k]));
    check({p, ".vec_addr"}, d_vec[k], 32'h100 + 32'(m_id[k]) * 32'd16);
    check({p, ".mask_q"}, 32'(d_mask[k]), 32'(m_mask[k]));
    check({p, ".pend_q"}, 32'(d_pend[k]), 32'(m_pend[k]));
    check({p, ".ovf_q"}, 32'(d_ovf[k]), 32'(m_ovf[k]));
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) for (int k = 0; k < 2; k++) step(k);
    @(negedge clk);
    for (int k = 0; k < 2; k++) compare_all(k);
  endtask
  task automatic wait_req(input int k, input logic want);
    for (int i = 0; i < 10 && d_req[k] !== want; i++) tick();
    check($sformatf("wait_req%0d=%0d", k, want), 32'(d_req[k]), 32'(want));
  endtask
  task automatic pulse(input logic [3:0] v);
    irq_src = v; tick(); irq_src = 0; tick();
  endtask
  task automatic ack();
    int_ack = 1; tick(); int_ack = 0;
  endtask
  task automatic ret();
    rfe = 1; tick(); rfe = 0;
  endtask
  initial begin
    #1 rst = 0;
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) compare_all(k);
    tick();
    rst = 1;
    repeat (4) tick();
    // single source: vector and service entry
    pulse(4'b0100);
    wait_req(0, 1);
    check("r33.pend", 32'(d_pend[0]), 32'h4);
    check("r33.id", 32'(d_id[0]), 32'd2);
    check("r33.vec", d_vec[0], 32'h120);
    ack();
    check("r33.pend_ack", 32'(d_pend[0]), 32'h0);
    check("r33.svc", 32'(d_svc[0]), 32'd1);
    check("r33.req_low", 32'(d_req[0]), 32'd0);
    ret();
    check("r33.svc_end", 32'(d_svc[0]), 32'd0);
    // simultaneous sources: lowest index first
    pulse(4'b1010);
    wait_req(0, 1);
    check("r34.id_first", 32'(d_id[0]), 32'd1);
    ack();
    ret();
    wait_req(0, 1);
    check("r34.id_second", 32'(d_id[0]), 32'd3);
    check("r34.vec_second", d_vec[0], 32'h130);
    ack();
    ret();
    // masking holds pend without requesting
    mask_wr = 1; mask_wdata = 4'b1110; tick(); mask_wr = 0;
    pulse(4'b0001);
    repeat (5) tick();
    check("r35.req_masked", 32'(d_req[0]), 32'd0);
    check("r35.pend0", 32'(d_pend[0][0]), 32'd1);
    mask_wr = 1; mask_wdata = 4'b1111; tick(); mask_wr = 0;
    wait_req(0, 1);
    check("r35.id", 32'(d_id[0]), 32'd0);
    ack();
    ret();
    tick();
    // overflow and edge coincident with ack
    pulse(4'b0010);
    pulse(4'b0010);
    repeat (4) tick();
    check("r36.ovf", 32'(d_ovf[0][1]), 32'd1);
    ovf_clr = 1; tick(); ovf_clr = 0;
    check("r36.ovf_clr", 32'(d_ovf[0][1]), 32'd0);
    check("r36.in_req", 32'(d_req[0]), 32'd1);
    irq_src = 4'b0010; tick(); irq_src = 0; tick();
    ack();
    check("r36.pend_kept", 32'(d_pend[0][1]), 32'd1);
    check("r36.svc", 32'(d_svc[0]), 32'd1);
    ret();
    wait_req(0, 1);
    ack();
    ret();
    repeat (2) tick();
    // level source re-requests after return
    irq_src = 4'b0001;
    wait_req(1, 1);
    check("r37.id", 32'(d_id[1]), 32'd0);
    ack();
    check("r37.svc", 32'(d_svc[1]), 32'd1);
    check("r37.pend_level", 32'(d_pend[1][0]), 32'd1);
    ret();
    tick();
    check("r37.rereq", 32'(d_req[1]), 32'd1);
    irq_src = 0;
    wait_req(1, 0);
    repeat (3) tick();
    // reset in service with the line held high
    irq_src = 4'b0001;
    wait_req(0, 1);
    ack();
    check("r38.svc", 32'(d_svc[0]), 32'd1);
    #2 rst = 0;
    #1 model_reset();
    for (int k = 0; k < 2; k++) compare_all(k);
    check("r38.req_rst", 32'(d_req[0]), 32'd0);
    check("r38.svc_rst", 32'(d_svc[0]), 32'd0);
    check("r38.vec_rst", d_vec[0], 32'h100);
    check("r38.mask_rst", 32'(d_mask[0]), 32'hF);
    repeat (2) tick();
    rst = 1;
    repeat (8) tick();
    check("r38.no_req", 32'(d_req[0]), 32'd0);
    check("r38.no_pend", 32'(d_pend[0]), 32'd0);
    // random traffic
    for (int c = 0; c < 2000; c++) begin
      irq_src = 4'($urandom) & 4'($urandom);
      mask_wr = $urandom_range(0, 15) == 0;
      mask_wdata = 4'($urandom);
      ovf_clr = $urandom_range(0, 15) == 0;
      int_ack = $urandom_range(0, 2) == 0;
      rfe = $urandom_range(0, 3) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
